// File: rtl/speech_phoneme_queue_if.sv
// ---------------------------------------------------------------------------
// speech_phoneme_queue_if
// CPU voice-port bus between the processor and the phoneme queue.
//   VoiceControl_H : port select from the CPU (level, held until acknowledged)
//   data           : phoneme word, slot 0 in the least significant PHONEME_W bits
//   VoiceDtack_L   : active-low acknowledge back to the CPU
// Modports: master = CPU side, slave = phoneme queue side.
// ---------------------------------------------------------------------------
interface speech_phoneme_queue_if #(
  parameter int DATA_W = 16
);
  logic              VoiceControl_H;
  logic [DATA_W-1:0] data;
  logic              VoiceDtack_L;

  modport master (output VoiceControl_H, output data, input VoiceDtack_L);
  modport slave  (input VoiceControl_H, input data, output VoiceDtack_L);
endinterface

// File: rtl/speech_phoneme_queue.sv
// ---------------------------------------------------------------------------
// speech_phoneme_queue
// Accepts phoneme words from the CPU voice port, splits each word into its
// non-zero phoneme codes and queues them in a FIFO. A speech sequencer drains
// the queue one phoneme at a time through the start/busy handshake with the
// phoneme player. The CPU is acknowledged as soon as its word is queued.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   cpu (slave modport)     : VoiceControl_H / data / VoiceDtack_L
//   phoneme_speech_busy     : player busy input
//   phoneme_sel             : code presented to the player (0 while idle)
//   start_phoneme_output    : start request level, held until busy is seen
//   phoneme_speech_finish   : one-cycle pulse per completed phoneme
//   fifo_count, fifo_full   : registered occupancy / full flag
//   queue_empty             : FIFO empty and sequencer idle
//   timeout_err             : sticky start-to-busy timeout flag
//
// Optional feature macro: SPEECH_TIMEOUT_EN enables the start-to-busy
// timeout (TIMEOUT_CYCLES). Without it timeout_err is constant 0.
// ---------------------------------------------------------------------------
module speech_phoneme_queue #(
  parameter int PHONEME_W         = 8,
  parameter int PHONEMES_PER_WORD = 2,
  parameter int DEPTH             = 16,
  parameter int TIMEOUT_CYCLES    = 1000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  speech_phoneme_queue_if.slave        cpu,
  input  logic                         phoneme_speech_busy,
  output logic [PHONEME_W-1:0]         phoneme_sel,
  output logic                         start_phoneme_output,
  output logic                         phoneme_speech_finish,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         fifo_full,
  output logic                         queue_empty,
  output logic                         timeout_err
);

  localparam int WORD_W = PHONEME_W * PHONEMES_PER_WORD;
  localparam int IDX_W  = (PHONEMES_PER_WORD > 1) ? $clog2(PHONEMES_PER_WORD) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PHONEMES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {B_IDLE, B_UNPACK, B_ACK} bus_state_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_SPEAK, S_DONE} spk_state_e;

  bus_state_e           bus_q;
  spk_state_e           spk_q;
  logic [WORD_W-1:0]    word_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 dtack_l_q;
  logic [PHONEME_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [PHONEME_W-1:0] sel_q;
  logic                 start_q;
  logic                 finish_q;
  logic                 terr_q;

  logic [PHONEME_W-1:0] cur_slot;
  logic                 slot_zero;
  logic                 push;
  logic                 pop;
  logic                 advance;

  // The word is shifted down as slots are consumed, so the slot under
  // consideration is always the low PHONEME_W bits.
  assign cur_slot  = word_q[PHONEME_W-1:0];
  assign slot_zero = (cur_slot == '0);
  assign pop       = (spk_q == S_IDLE) && (count_q != '0);
  // A full FIFO still accepts a push when the sequencer pops on the same edge.
  assign push      = (bus_q == B_UNPACK) && !slot_zero && (!fifo_full || pop);
  assign advance   = (bus_q == B_UNPACK) && (slot_zero || push);

  // -------------------------------------------------------------------------
  // Bus FSM: latch word, unpack one slot per cycle, hold acknowledge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q     <= B_IDLE;
      idx_q     <= '0;
      dtack_l_q <= 1'b1;
    end else begin
      case (bus_q)
        B_IDLE: begin
          if (cpu.VoiceControl_H) begin
            idx_q <= '0;
            bus_q <= B_UNPACK;
          end
        end
        B_UNPACK: begin
          if (advance) begin
            if (idx_q == LAST_IDX) begin
              bus_q     <= B_ACK;
              dtack_l_q <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        B_ACK: begin
          if (!cpu.VoiceControl_H) begin
            bus_q     <= B_IDLE;
            dtack_l_q <= 1'b1;
          end
        end
        default: bus_q <= B_IDLE;
      endcase
    end
  end

  // Word shift register carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (bus_q == B_IDLE && cpu.VoiceControl_H) begin
      word_q <= cpu.data;
    end else if (advance) begin
      word_q <= word_q >> PHONEME_W;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cur_slot;
  end

`ifdef SPEECH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q;
`endif

  // -------------------------------------------------------------------------
  // Speech sequencer: pop, request start, wait busy high then low, finish.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_q    <= S_IDLE;
      sel_q    <= '0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      terr_q   <= 1'b0;
`ifdef SPEECH_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      finish_q <= 1'b0;
      case (spk_q)
        S_IDLE: begin
          if (pop) begin
            sel_q   <= mem_q[rd_ptr_q];
            start_q <= 1'b1;
            spk_q   <= S_WAIT_BUSY;
`ifdef SPEECH_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        S_WAIT_BUSY: begin
          if (phoneme_speech_busy) begin
            start_q <= 1'b0;
            spk_q   <= S_SPEAK;
          end
`ifdef SPEECH_TIMEOUT_EN
          // Player never answered: abandon this phoneme without a finish.
          else if (to_cnt_q == TO_LAST) begin
            start_q <= 1'b0;
            sel_q   <= '0;
            terr_q  <= 1'b1;
            spk_q   <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_SPEAK: begin
          if (!phoneme_speech_busy) begin
            finish_q <= 1'b1;
            spk_q    <= S_DONE;
          end
        end
        S_DONE: begin
          sel_q <= '0;
          spk_q <= S_IDLE;
        end
        default: spk_q <= S_IDLE;
      endcase
    end
  end

`ifndef SPEECH_TIMEOUT_EN
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign cpu.VoiceDtack_L          = dtack_l_q;
  assign phoneme_sel               = sel_q;
  assign start_phoneme_output      = start_q;
  assign phoneme_speech_finish     = finish_q;
  assign fifo_count                = count_q;
  assign fifo_full                 = (count_q == DEPTH_CNT);
  assign queue_empty               = (count_q == '0) && (spk_q == S_IDLE);
  assign timeout_err               = terr_q;

endmodule

// File: doc/speech_phoneme_queue.md
# speech_phoneme_queue

Buffered successor to the single-word phoneme controller: accepts phoneme words from the CPU voice port, splits each word into its non-zero phoneme codes, and queues them in a FIFO. A speech engine sequencer drains the queue one phoneme at a time through the start/busy handshake with the phoneme player. The CPU is acknowledged as soon as a word is queued, not when speech ends, so it can issue multiple words back-to-back.

## Interface
- PHONEME_W, 8, bits per phoneme code
- PHONEMES_PER_WORD, 2, phoneme slots per bus word; data width = PHONEME_W*PHONEMES_PER_WORD
- DEPTH, 16, FIFO entries, power of two, ≥2
- TIMEOUT_CYCLES, 1000000, start-to-busy limit (used only with SPEECH_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- VoiceControl_H  in  1  CPU voice-port select, level, held until Dtack
- data  in  PHONEME_W*PHONEMES_PER_WORD  phoneme word; slot 0 = bits [PHONEME_W-1:0]
- VoiceDtack_L  out  1  active-low acknowledge to CPU
- phoneme_speech_busy  in  1  phoneme player busy
- phoneme_sel  out  PHONEME_W  phoneme code presented to player
- start_phoneme_output  out  1  start request to player
- phoneme_speech_finish  out  1  one-cycle pulse per completed phoneme
- fifo_count  out  $clog2(DEPTH+1)  current occupancy
- fifo_full  out  1  count == DEPTH
- queue_empty  out  1  count == 0 and speech FSM in S_IDLE
- timeout_err  out  1  sticky timeout flag

## Operation
- Reset: both FSMs idle, FIFO empty; VoiceDtack_L=1, phoneme_sel=0, start_phoneme_output=0, phoneme_speech_finish=0, fifo_count=0, fifo_full=0, queue_empty=1, timeout_err=0.
- Bus FSM B_IDLE → B_UNPACK → B_ACK:
  - B_IDLE: VoiceControl_H=1 → latch data, slot index=0, go B_UNPACK.
  - B_UNPACK: one slot per cycle, slot 0 first. Zero slot: skip, index++. Non-zero slot with !fifo_full: push, index++. Non-zero slot with fifo_full: stall, index holds. After last slot → B_ACK.
  - B_ACK: VoiceDtack_L=0; stay while VoiceControl_H=1; VoiceControl_H=0 → B_IDLE, Dtack=1 the next cycle.
  - All-zero word: no pushes, acknowledged after PHONEMES_PER_WORD cycles.
- Speech FSM S_IDLE → S_WAIT_BUSY → S_SPEAK → S_DONE:
  - S_IDLE: phoneme_sel=0. FIFO non-empty → pop head into sel register, go S_WAIT_BUSY.
  - S_WAIT_BUSY: start_phoneme_output=1 (level). busy=1 → S_SPEAK.
  - S_SPEAK: start=0. busy=0 → S_DONE.
  - S_DONE: phoneme_speech_finish=1 for one cycle → S_IDLE.
  - phoneme_sel holds the registered code in every state except S_IDLE.
- FIFO: push and pop in the same cycle are legal at any occupancy, including full (pop frees the slot on the same edge, count unchanged). Pointers wrap modulo DEPTH. Pop never happens when empty.
- Reset asserted mid-operation: all state clears immediately; queued phonemes are discarded; the player sees start drop asynchronously.

## Timing
- A word arriving with an empty FIFO and idle engine: first push at edge T+1 after VoiceControl_H is sampled at edge T; start_phoneme_output rises after edge T+2.
- VoiceDtack_L falls PHONEMES_PER_WORD cycles after the latch edge when there are no stalls; each full-stall cycle adds one cycle.
- Back-to-back phonemes: S_DONE → S_IDLE → pop costs 2 cycles between a finish pulse and the next start.
- fifo_count and fifo_full are registered and reflect the previous edge's push/pop.

## Configuration
- SPEECH_TIMEOUT_EN defined: a counter runs in S_WAIT_BUSY. Reaching TIMEOUT_CYCLES without busy → drop start, set timeout_err (sticky until reset), return to S_IDLE with no finish pulse; the phoneme is discarded. Counter clears on entering S_WAIT_BUSY.
- SPEECH_TIMEOUT_EN not defined: no counter; S_WAIT_BUSY waits indefinitely; timeout_err is tied to 0.

## Test plan
- Word 16'h2A15, player busy 5 cycles per phoneme → phoneme_sel 8'h15 then 8'h2A, two finish pulses, Dtack low at 2 cycles after latch.
- Word 16'h3000 → only 8'h30 queued, fifo_count peaks at 1; word 16'h0000 → acknowledged, no start.
- 9 words of two non-zero codes with busy held high, DEPTH=16 → 16 queued plus 1 in engine, 9th word stalls, Dtack withheld until busy drops and a slot frees.
- Push and pop in the same cycle at fifo_count=16 → count stays 16, no code lost, order preserved.
- rst_n pulsed low with 5 entries queued and start high → all outputs at reset values at once, no finish pulse after release.
- With SPEECH_TIMEOUT_EN and TIMEOUT_CYCLES=20, busy never asserted → start drops after 20 cycles, timeout_err=1, next queued phoneme starts.
